// File: rtl/reservation_station_if.sv
// Bundle of decode, writeback-broadcast and issue-port signals around the reservation station.
// master = surrounding pipeline, slave = reservation station.
interface reservation_station_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [116:0]  in_inst;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic          in_md_valid;
  logic          wb_valid;
  logic          wb_fp;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [13:0]   out_ctrl;
  logic [31:0]   out_op1;
  logic [31:0]   out_op2;
  logic [31:0]   out_memdata;
  logic [4:0]    out_rd;
  logic [CW-1:0] count;

  modport master (
    output flush, in_valid, in_inst, in_rs1, in_rs2, in_md_valid,
           wb_valid, wb_fp, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_op1, out_op2, out_memdata, out_rd, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_rs1, in_rs2, in_md_valid,
           wb_valid, wb_fp, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_op1, out_op2, out_memdata, out_rd, count
  );
endinterface

// File: rtl/reservation_station.sv
// Compacting age-ordered reservation station: captures operands from the writeback bus
// by source-register tag and issues the oldest ready entry.
module reservation_station #(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  reservation_station_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [13:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic        op1_v;
    logic [4:0]  tag1;
    logic [31:0] op2;
    logic        op2_v;
    logic [4:0]  tag2;
    logic [31:0] md;
    logic        md_v;
  } entry_t;

  entry_t          ent_reg  [DEPTH];
  entry_t          ent_next [DEPTH];
  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] ready;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   wpos;
  logic [IW-1:0]   sel;
  logic            any_ready;
  logic            issue;
  logic            alloc;
  logic            space;
  logic            wb_hit;
  entry_t          new_ent;

  // Integer x0 is hardwired, so a broadcast to it is never a real producer.
  assign wb_hit = bus.wb_valid & ~(~bus.wb_fp & (bus.wb_addr == 5'd0));

  function automatic entry_t wake(entry_t e, logic hit, logic fp, logic [4:0] addr,
                                  logic [31:0] data);
    entry_t r;
    r = e;
    if (hit && (fp == e.ctrl[13])) begin
      if (!e.op1_v && (e.tag1 == addr)) begin
        r.op1   = data;
        r.op1_v = 1'b1;
      end
      if (!e.op2_v && (e.tag2 == addr)) begin
        r.op2   = data;
        r.op2_v = 1'b1;
      end
      if (!e.md_v && (e.tag2 == addr)) begin
        r.md   = data;
        r.md_v = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    new_ent       = '0;
    new_ent.md    = bus.in_inst[116:85];
    new_ent.ctrl  = bus.in_inst[84:71];
    new_ent.op2   = bus.in_inst[70:39];
    new_ent.op2_v = bus.in_inst[38];
    new_ent.op1   = bus.in_inst[37:6];
    new_ent.op1_v = bus.in_inst[5];
    new_ent.rd    = bus.in_inst[4:0];
    new_ent.tag1  = bus.in_rs1;
    new_ent.tag2  = bus.in_rs2;
    new_ent.md_v  = bus.in_inst[77] ? bus.in_md_valid : 1'b1;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
    assign ready[gi] = v_reg[gi] & ent_reg[gi].op1_v & ent_reg[gi].op2_v & ent_reg[gi].md_v;
  end

  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel = IW'(i);
    end
  end

  assign any_ready = |ready;
  assign space     = (count_reg < CW'(DEPTH));
  assign issue     = any_ready & bus.out_ready;
  assign alloc     = bus.in_valid & space;
  assign wpos      = count_reg - {{(CW-1){1'b0}}, issue};
  assign count_next = count_reg + {{(CW-1){1'b0}}, alloc} - {{(CW-1){1'b0}}, issue};

  // Each slot takes its upper neighbour when the issued entry sits at or below it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    entry_t src_ent;
    logic   src_v;
    logic   take_upper;
    logic   write_here;

    assign take_upper = issue && (IW'(gi) >= sel);
    assign write_here = alloc && (wpos == CW'(gi));

    if (gi < DEPTH - 1) begin : g_mid
      assign src_ent = take_upper ? ent_reg[gi+1] : ent_reg[gi];
      assign src_v   = take_upper ? v_reg[gi+1]   : v_reg[gi];
    end else begin : g_top
      assign src_ent = ent_reg[gi];
      assign src_v   = take_upper ? 1'b0 : v_reg[gi];
    end

    assign ent_next[gi] = wake(write_here ? new_ent : src_ent, wb_hit, bus.wb_fp,
                               bus.wb_addr, bus.wb_data);
    assign v_next[gi]   = write_here | src_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else if (bus.flush) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else begin
      v_reg     <= v_next;
      count_reg <= count_next;
    end
  end

  // Payloads are qualified by v_reg, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_reg[i] <= ent_next[i];
    end
  end

  assign bus.in_ready    = space;
  assign bus.count       = count_reg;
  assign bus.out_valid   = any_ready;
  assign bus.out_ctrl    = any_ready ? ent_reg[sel].ctrl : '0;
  assign bus.out_op1     = any_ready ? ent_reg[sel].op1  : '0;
  assign bus.out_op2     = any_ready ? ent_reg[sel].op2  : '0;
  assign bus.out_memdata = any_ready ? ent_reg[sel].md   : '0;
  assign bus.out_rd      = any_ready ? ent_reg[sel].rd   : '0;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, multi-cycle corner sequences and
// random traffic, all compared against a queue-based age-ordered model.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam int ALU   = 32'h0004;
  localparam int ST    = 32'h0040;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  reservation_station_if #(.DEPTH(DEPTH)) bus ();

  reservation_station #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  typedef struct {
    logic [13:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic        o1v;
    logic [4:0]  t1;
    logic [31:0] op2;
    logic        o2v;
    logic [4:0]  t2;
    logic [31:0] md;
    logic        mdv;
  } ment_t;

  ment_t q[$];

  typedef struct {
    logic        iv;
    logic [13:0] ctrl;
    logic [31:0] op1;
    logic        o1v;
    logic [4:0]  rs1;
    logic [31:0] op2;
    logic        o2v;
    logic [4:0]  rs2;
    logic        mdv;
    logic [4:0]  rd;
    logic        wbv;
    logic        wbfp;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [31:0] e_md;
    logic [4:0]  e_rd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int iv, int ctrl, int op1, int o1v, int rs1, int op2, int o2v,
                               int rs2, int mdv, int rd, int wbv, int wbfp, int wba, int wbd,
                               int ordy, int fl, int e_ov, int e_op1, int e_op2, int e_md,
                               int e_rd, int e_cnt);
    vec_t r;
    r.iv = 1'(iv);     r.ctrl = 14'(ctrl); r.op1 = 32'(op1); r.o1v = 1'(o1v);
    r.rs1 = 5'(rs1);   r.op2 = 32'(op2);   r.o2v = 1'(o2v);  r.rs2 = 5'(rs2);
    r.mdv = 1'(mdv);   r.rd = 5'(rd);      r.wbv = 1'(wbv);  r.wbfp = 1'(wbfp);
    r.wba = 5'(wba);   r.wbd = 32'(wbd);   r.ordy = 1'(ordy); r.fl = 1'(fl);
    r.e_ov = 1'(e_ov); r.e_op1 = 32'(e_op1); r.e_op2 = 32'(e_op2); r.e_md = 32'(e_md);
    r.e_rd = 5'(e_rd); r.e_cnt = 3'(e_cnt);
    return r;
  endfunction

  // Reference model: a plain age-ordered list with the wakeup rules applied per cycle.
  function automatic ment_t wk(ment_t e);
    ment_t r;
    r = e;
    if (bus.wb_valid && (bus.wb_fp == e.ctrl[13]) && !(!bus.wb_fp && bus.wb_addr == 5'd0)) begin
      if (!e.o1v && e.t1 == bus.wb_addr) begin r.op1 = bus.wb_data; r.o1v = 1'b1; end
      if (!e.o2v && e.t2 == bus.wb_addr) begin r.op2 = bus.wb_data; r.o2v = 1'b1; end
      if (!e.mdv && e.t2 == bus.wb_addr) begin r.md  = bus.wb_data; r.mdv = 1'b1; end
    end
    return r;
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].o1v && q[i].o2v && q[i].mdv) return i;
    end
    return -1;
  endfunction

  function automatic logic [127:0] dut_out();
    return 128'({bus.out_valid, bus.out_ctrl, bus.out_op1, bus.out_op2, bus.out_memdata, bus.out_rd});
  endfunction

  function automatic logic [127:0] model_out();
    int idx;
    idx = first_ready();
    if (idx < 0) return '0;
    return 128'({1'b1, q[idx].ctrl, q[idx].op1, q[idx].op2, q[idx].md, q[idx].rd});
  endfunction

  task automatic model_check();
    check("model_out", dut_out(), model_out());
    check("model_count", 128'(bus.count), 128'(q.size()));
    check("model_in_ready", 128'(bus.in_ready), 128'(q.size() < DEPTH));
  endtask

  task automatic model_step();
    int    idx;
    bit    iss;
    bit    alc;
    ment_t n;
    idx = first_ready();
    iss = (idx >= 0) && bus.out_ready;
    alc = bus.in_valid && (q.size() < DEPTH);
    if (bus.flush) begin
      q.delete();
      return;
    end
    if (iss) begin
      $display("issue rd=%0d ctrl=%h op1=%h op2=%h md=%h", q[idx].rd, q[idx].ctrl,
               q[idx].op1, q[idx].op2, q[idx].md);
      q.delete(idx);
    end
    foreach (q[i]) q[i] = wk(q[i]);
    if (alc) begin
      n.md   = bus.in_inst[116:85];
      n.ctrl = bus.in_inst[84:71];
      n.op2  = bus.in_inst[70:39];
      n.o2v  = bus.in_inst[38];
      n.op1  = bus.in_inst[37:6];
      n.o1v  = bus.in_inst[5];
      n.rd   = bus.in_inst[4:0];
      n.t1   = bus.in_rs1;
      n.t2   = bus.in_rs2;
      n.mdv  = n.ctrl[6] ? bus.in_md_valid : 1'b1;
      q.push_back(wk(n));
    end
  endtask

  task automatic cycle();
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;     bus.in_valid = 1'b0;  bus.in_inst = '0;
    bus.in_rs1 = '0;      bus.in_rs2 = '0;      bus.in_md_valid = 1'b0;
    bus.wb_valid = 1'b0;  bus.wb_fp = 1'b0;     bus.wb_addr = '0;
    bus.wb_data = '0;     bus.out_ready = 1'b0;
  endtask

  task automatic drive_inst(input int ctrl, input int rd, input int op1, input int o1v,
                            input int rs1, input int op2, input int o2v, input int rs2);
    bus.in_valid    = 1'b1;
    bus.in_inst     = {32'h0, 14'(ctrl), 32'(op2), 1'(o2v), 32'(op1), 1'(o1v), 5'(rd)};
    bus.in_rs1      = 5'(rs1);
    bus.in_rs2      = 5'(rs2);
    bus.in_md_valid = 1'b0;
  endtask

  task automatic bcast(input int addr, input int data);
    bus.wb_valid = 1'b1;
    bus.wb_fp    = 1'b0;
    bus.wb_addr  = 5'(addr);
    bus.wb_data  = 32'(data);
  endtask

  task automatic apply_row(input vec_t r);
    bus.in_valid    = r.iv;
    bus.in_inst     = {32'h0, r.ctrl, r.op2, r.o2v, r.op1, r.o1v, r.rd};
    bus.in_rs1      = r.rs1;
    bus.in_rs2      = r.rs2;
    bus.in_md_valid = r.mdv;
    bus.wb_valid    = r.wbv;
    bus.wb_fp       = r.wbfp;
    bus.wb_addr     = r.wba;
    bus.wb_data     = r.wbd;
    bus.out_ready   = r.ordy;
    bus.flush       = r.fl;
  endtask

  initial begin
    //            iv ctrl op1 o1v rs1 op2 o2v rs2 mdv rd  wbv fp wba wbd      ordy fl  ov op1      op2  md       rd cnt
    vecs[0]  = mkv(1, ALU, 5,  1,  0,  7,  1,  0,  0,  3,  0, 0, 0, 0,        0, 0,  1, 5,       7,   0,       3,  1);
    vecs[1]  = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,        1, 0,  0, 0,       0,   0,       0,  0);
    vecs[2]  = mkv(1, ALU, 0,  0,  4,  2,  1,  0,  0,  10, 0, 0, 0, 0,        0, 0,  0, 0,       0,   0,       0,  1);
    vecs[3]  = mkv(1, ALU, 11, 1,  0,  22, 1,  0,  0,  11, 0, 0, 0, 0,        0, 0,  1, 11,      22,  0,       11, 2);
    vecs[4]  = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,        1, 0,  0, 0,       0,   0,       0,  1);
    vecs[5]  = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  1, 0, 4, 'h1234,   0, 0,  1, 'h1234,  2,   0,       10, 1);
    vecs[6]  = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,        1, 0,  0, 0,       0,   0,       0,  0);
    vecs[7]  = mkv(1, ALU, 0,  0,  2,  'h77,1, 0,  0,  12, 0, 0, 0, 0,        0, 0,  0, 0,       0,   0,       0,  1);
    vecs[8]  = mkv(1, ALU, 'h55,1, 0,  0,  0,  0,  0,  13, 1, 1, 2, 'hAAAA,   0, 0,  0, 0,       0,   0,       0,  2);
    vecs[9]  = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  1, 0, 0, 'hBBBB,   0, 0,  0, 0,       0,   0,       0,  2);
    vecs[10] = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  1, 0, 2, 'hCCCC,   0, 0,  1, 'hCCCC,  'h77,0,       12, 2);
    vecs[11] = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,        1, 0,  0, 0,       0,   0,       0,  1);
    vecs[12] = mkv(1, ALU, 1,  1,  0,  1,  1,  0,  0,  1,  0, 0, 0, 0,        1, 1,  0, 0,       0,   0,       0,  0);
    vecs[13] = mkv(1, ST,  1,  1,  0,  2,  1,  9,  0,  14, 0, 0, 0, 0,        0, 0,  0, 0,       0,   0,       0,  1);
    vecs[14] = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  1, 0, 9, 'hDEAD,   0, 0,  1, 1,       2,   'hDEAD,  14, 1);
    vecs[15] = mkv(1, ST,  1,  1,  0,  3,  1,  9,  0,  15, 1, 0, 9, 'hBEEF,   1, 0,  1, 1,       3,   'hBEEF,  15, 1);
    vecs[16] = mkv(0, ALU, 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,        1, 0,  0, 0,       0,   0,       0,  0);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_count", 128'(bus.count), 128'(0));
    check("reset_out", dut_out(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      apply_row(vecs[i]);
      cycle();
      check($sformatf("vec%0d", i),
            128'({bus.out_valid, bus.out_op1, bus.out_op2, bus.out_memdata, bus.out_rd, bus.count}),
            128'({vecs[i].e_ov, vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_md, vecs[i].e_rd, vecs[i].e_cnt}));
    end
    idle();

    // Full queue, mid-queue issue with shifting wakeup, then simultaneous alloc and issue.
    drive_inst(ALU, 20, 0, 0, 5, 1, 1, 0);     cycle();
    drive_inst(ALU, 21, 'h21, 1, 0, 2, 1, 0);  cycle();
    drive_inst(ALU, 22, 0, 0, 6, 3, 1, 0);     cycle();
    drive_inst(ALU, 23, 0, 0, 7, 4, 1, 0);     cycle();
    check("full_in_ready", 128'(bus.in_ready), 128'(0));
    check("full_count", 128'(bus.count), 128'(4));
    check("full_sel_rd", 128'(bus.out_rd), 128'(21));
    drive_inst(ALU, 24, 'h24, 1, 0, 5, 1, 0);  cycle();
    check("full_hold_count", 128'(bus.count), 128'(4));
    bus.out_ready = 1'b1;
    bcast(6, 'h66);                            cycle();
    check("mid_issue_count", 128'(bus.count), 128'(3));
    check("mid_issue_sel", 128'({bus.out_rd, bus.out_op1}), 128'({5'd22, 32'h66}));
    bcast(5, 'h55);                            cycle();
    check("alloc_issue_count", 128'(bus.count), 128'(3));
    check("order_e0_rd", 128'(bus.out_rd), 128'(20));
    bus.in_valid = 1'b0;
    bcast(7, 'h77);                            cycle();
    check("order_e3_rd", 128'(bus.out_rd), 128'(23));
    bus.wb_valid = 1'b0;                       cycle();
    check("order_e4_rd", 128'(bus.out_rd), 128'(24));
    cycle();
    check("drain_count", 128'(bus.count), 128'(0));
    idle();

    // Flush with three resident entries and a concurrent allocate.
    drive_inst(ALU, 1, 0, 0, 20, 1, 1, 0);     cycle();
    drive_inst(ALU, 2, 0, 0, 21, 1, 1, 0);     cycle();
    drive_inst(ALU, 3, 0, 0, 22, 1, 1, 0);     cycle();
    check("pre_flush_count", 128'(bus.count), 128'(3));
    drive_inst(ALU, 4, 9, 1, 0, 9, 1, 0);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;                      cycle();
    check("flush_count", 128'(bus.count), 128'(0));
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    idle();                                    cycle();
    check("post_flush_out_valid", 128'(bus.out_valid), 128'(0));

    // Asynchronous reset between clock edges.
    drive_inst(ALU, 5, 1, 1, 0, 2, 1, 0);      cycle();
    drive_inst(ALU, 6, 3, 1, 0, 4, 1, 0);      cycle();
    idle();
    check("pre_reset_count", 128'(bus.count), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", dut_out(), 128'(0));
    check("async_reset_count", 128'(bus.count), 128'(0));
    check("async_reset_in_ready", 128'(bus.in_ready), 128'(1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int c = 0; c < 600; c++) begin
      logic [13:0] rc;
      rc = 14'($urandom());
      bus.in_valid    = ($urandom_range(0, 9) < 6);
      bus.in_inst     = {32'($urandom()), rc, 32'($urandom()), 1'($urandom_range(0, 1)),
                         32'($urandom()), 1'($urandom_range(0, 1)), 5'($urandom())};
      bus.in_rs1      = 5'($urandom_range(0, 7));
      bus.in_rs2      = 5'($urandom_range(0, 7));
      bus.in_md_valid = 1'($urandom_range(0, 1));
      bus.wb_valid    = 1'($urandom_range(0, 1));
      bus.wb_fp       = 1'($urandom_range(0, 1));
      bus.wb_addr     = 5'($urandom_range(0, 7));
      bus.wb_data     = 32'($urandom());
      bus.out_ready   = 1'($urandom_range(0, 1));
      bus.flush       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle();
    model_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
# reservation_station

Holds decoded instructions from the decode/register-read stage until all of their operands are available, then issues them in age order to the execute stage. It sits between the decode/register-read stage, which produces a 117-bit packed instruction word with per-operand valid bits, and the ALU/memory issue port. Pending operands are captured from the writeback broadcast bus using the source register address as the tag. Entries are stored in a compacting, age-ordered queue, and the oldest ready entry issues first.

## Interface
- DEPTH, 4: number of entries. Legal values are 2 to 16.
- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  space available. Equals count < DEPTH.
- in_inst  in  117  packed word, fields as follows:
  - [116:85] memdata
  - [84:71] ctrl = {fp, aluop[5:0], memwrite, memread, memtoreg, branch, regwrite, dispatch_control[1:0]}
  - [70:39] op2
  - [38] op2_valid
  - [37:6] op1
  - [5] op1_valid
  - [4:0] rd
- in_rs1  in  5  tag for op1.
- in_rs2  in  5  tag for op2 and memdata.
- in_md_valid  in  1  memdata valid. Only meaningful when ctrl memwrite (bit 77) is 1.
- wb_valid  in  1  writeback broadcast valid.
- wb_fp  in  1  broadcast register class: 1 = fp, 0 = integer.
- wb_addr  in  5  broadcast destination register.
- wb_data  in  32  broadcast value.
- out_valid  out  1  an issuable entry exists.
- out_ready  in  1  execute accepts.
- out_ctrl  out  14  ctrl field of the issued entry.
- out_op1, out_op2, out_memdata  out  32 each  operand values of the issued entry.
- out_rd  out  5  destination register of the issued entry.
- count  out  clog2(DEPTH)+1  occupancy.

## Operation
- **Entry contents:** v, ctrl, rd, op1/op1_v/tag1, op2/op2_v/tag2, md/md_v.
- **Allocation:**
  - md_v = in_md_valid when memwrite is 1; otherwise md_v is forced to 1.
  - Entries [0..count-1] are valid, and entry 0 is the oldest.
- **Ready condition:** v & op1_v & op2_v & md_v.
- **Select:** the lowest-index ready entry. The out_* ports are driven combinationally from it; when out_valid is 0 they are 0.
- **Issue fire:** out_valid & out_ready. The selected entry is removed. Every entry above it shifts down by one, preserving order.
- **Allocate fire:** in_valid & in_ready. The new entry is written at index count, or at count-1 if an issue fires in the same cycle.
- **Wakeup:**
  - Condition: wb_valid, wb_fp equals the entry's ctrl fp bit, and the operand is invalid with tag equal to wb_addr.
  - Effect: the operand gets wb_data and its valid bit is set. op2 and md are both checked against tag2.
  - Integer broadcasts to wb_addr 0 never wake anything.
  - Wakeup applies to resident entries, including ones shifting this cycle.
  - Wakeup also applies to the entry being allocated this cycle (same-cycle capture).
- **Flush:** clears all v bits and sets count to 0. Allocate and issue in the same cycle are discarded; flush has priority.
- **count arithmetic:** count_next = count + alloc - issue. It never exceeds DEPTH and never underflows.

## Timing
- **Reset values:** all v = 0, count = 0, in_ready = 1, out_valid = 0, all out_* = 0. Entry payloads need no reset.
- **Allocation latency:** an entry allocated fully ready at edge N can issue in cycle N+1. There is no bypass from input to output.
- **Wakeup latency:** an operand woken at edge N makes the entry ready in cycle N+1. Issue never uses same-cycle wb_data.
- **Full:**
  - in_ready = 0, even if an issue fires in that cycle; there is no full-bypass.
  - in_valid while full is ignored. Decode must hold the instruction.
- **Empty:** out_valid = 0.
- **Output stall:** out_valid and the selected entry remain stable while out_ready = 0, unless an older entry becomes ready. Selection always follows the oldest ready entry.
- **Reset mid-operation:** rst_n low clears state immediately, regardless of clk.

## Test plan
- **Basic issue:** reset, then allocate one fully valid ALU op (op1 = 5, op2 = 7, rd = 3). Expect out_valid in the next cycle with out_op1 = 5, out_op2 = 7, out_rd = 3. Count goes 1 then 0 after the out_ready fire.
- **Wakeup and age order:**
  - Allocate entry A with op1 pending (tag x4), then entry B fully valid.
  - Expect B to issue first.
  - Then broadcast wb_addr = 4, data 0x1234, wb_fp = 0. Expect A to issue in the following cycle with out_op1 = 0x1234.
- **Class and x0 filtering:**
  - A pending integer tag x2 with broadcast wb_fp = 1, addr 2: no wakeup.
  - A pending tag x0 with integer broadcast to addr 0: no wakeup.
  - Integer broadcast to addr 2: wakeup.
- **Full and simultaneous:**
  - Fill all 4 entries. Expect in_ready = 0 and a held in_valid ignored.
  - Fire an issue of entry 1. Expect order 0, 2, 3 preserved and count = 3.
  - Next cycle, allocate and issue together. Expect count to stay at 3.
- **Store data:**
  - Allocate a store with in_md_valid = 0 and tag2 = x9. Expect no issue.
  - Then the allocate-cycle broadcast of x9 = 0xDEAD in the same cycle. Expect issue next cycle with out_memdata = 0xDEAD.
- **Flush and reset:**
  - Flush with 3 entries and a concurrent allocate. Expect count = 0 and out_valid = 0 next cycle.
  - Assert rst_n low asynchronously mid-cycle. Expect all outputs at reset values immediately.
